// File: rtl/logic_pkg.sv
// Shared operation codes for the bitwise logic unit and anything that drives it.
package logic_pkg;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOTA = 3'd2;
  localparam logic [2:0] OP_NOTB = 3'd3;
  localparam logic [2:0] OP_NAND = 3'd4;
  localparam logic [2:0] OP_NOR  = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_XNOR = 3'd7;

endpackage

// File: rtl/logic_func_comb.sv
// Purely combinational two-operand bitwise function selected by a 3-bit op code.
module logic_func_comb
  import logic_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  output logic [WIDTH-1:0] y
);

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_NOTA: y = ~a;
      OP_NOTB: y = ~b;
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_XOR:  y = a ^ b;
      OP_XNOR: y = ~(a ^ b);
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage valid/ready pipelined bitwise logic unit with result flags and a
// wrapping count of consumed results.
module logic_unit_pipe #(
  parameter int WIDTH   = 8,
  parameter int COUNT_W = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic [2:0]         in_op,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [WIDTH-1:0]   out_y,
  output logic               out_zero,
  output logic               out_ones,
  output logic               out_par,
  input  logic               clr_count,
  output logic [COUNT_W-1:0] xfer_count
);

  logic [WIDTH-1:0] y_comb;
  logic [WIDTH-1:0] y_p1;
  logic             vld_p1;
  logic             s1_adv;
  logic             s2_adv;

  function automatic logic flag_zero(input logic [WIDTH-1:0] v);
    return ~|v;
  endfunction

  function automatic logic flag_ones(input logic [WIDTH-1:0] v);
    return &v;
  endfunction

  function automatic logic flag_par(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic_func_comb #(.WIDTH(WIDTH)) u_func (
    .a  (in_a),
    .b  (in_b),
    .op (in_op),
    .y  (y_comb)
  );

  // Each stage moves when the stage behind it is empty or draining.
  assign s2_adv   = ~out_valid | out_ready;
  assign s1_adv   = ~vld_p1 | s2_adv;
  assign in_ready = s1_adv;

  // Stage 1: function result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1 <= 1'b0;
    end else if (s1_adv) begin
      vld_p1 <= in_valid;
    end
  end

  always_ff @(posedge clk) begin
    if (in_valid && s1_adv) begin
      y_p1 <= y_comb;
    end
  end

  // Stage 2: result and flags registered together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_zero  <= 1'b0;
      out_ones  <= 1'b0;
      out_par   <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= vld_p1;
      if (vld_p1) begin
        out_y    <= y_p1;
        out_zero <= flag_zero(y_p1);
        out_ones <= flag_ones(y_p1);
        out_par  <= flag_par(y_p1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xfer_count <= '0;
    end else if (clr_count) begin
      xfer_count <= '0;
    end else if (out_valid && out_ready) begin
      xfer_count <= xfer_count + COUNT_W'(1);
    end
  end

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Randomised and directed bench for logic_unit_pipe against a truth-table scoreboard model.
module tb_logic_unit_pipe;

  typedef struct packed {
    logic [7:0] y;
    logic       z;
    logic       o;
    logic       p;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [2:0] in_op;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_y;
  logic       out_zero;
  logic       out_ones;
  logic       out_par;
  logic       clr_count;
  logic [3:0] xfer_count;

  int n_checks = 0;
  int n_pass   = 0;
  exp_t exp_q[$];
  // Truth table per op, indexed by {a_bit, b_bit}.
  logic [3:0] tt [0:7] = '{4'b1000, 4'b1110, 4'b0011, 4'b0101,
                           4'b0111, 4'b0001, 4'b0110, 4'b1001};

  logic_unit_pipe #(.WIDTH(8), .COUNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .out_valid(out_valid),
    .out_ready(out_ready), .out_y(out_y), .out_zero(out_zero),
    .out_ones(out_ones), .out_par(out_par), .clr_count(clr_count),
    .xfer_count(xfer_count)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    exp_t e;
    logic [3:0] t;
    int pop;
    t = tt[op];
    pop = 0;
    for (int i = 0; i < 8; i++) begin
      e.y[i] = t[{a[i], b[i]}];
      if (e.y[i]) pop++;
    end
    e.z = (pop == 0);
    e.o = (pop == 8);
    e.p = (pop % 2 == 1);
    return e;
  endfunction

  task automatic drive_cycle(input bit iv, input logic [7:0] a, input logic [7:0] b,
                             input logic [2:0] op, input bit ordy, input bit clr,
                             output bit acc, output bit cons, output bit have_ex, output exp_t ex);
    @(negedge clk);
    in_valid  = iv;
    in_a      = a;
    in_b      = b;
    in_op     = op;
    out_ready = ordy;
    clr_count = clr;
    #1;
    acc  = in_valid && in_ready;
    cons = out_valid && out_ready;
    have_ex = 1'b0;
    ex = '0;
    if (cons && exp_q.size() > 0) begin
      ex = exp_q.pop_front();
      have_ex = 1'b1;
    end
    if (acc) exp_q.push_back(model(a, b, op));
  endtask

  task automatic idle(input bit ordy, output bit cons, output bit have_ex, output exp_t ex);
    bit acc;
    drive_cycle(1'b0, 8'h00, 8'h00, 3'd0, ordy, 1'b0, acc, cons, have_ex, ex);
  endtask

  task automatic send_one(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op,
                          output bit ok, output logic [7:0] y, output exp_t ex);
    bit acc, cons, hv;
    ok = 1'b0;
    y = '0;
    drive_cycle(1'b1, a, b, op, 1'b1, 1'b0, acc, cons, hv, ex);
    for (int i = 0; i < 20 && !ok; i++) begin
      idle(1'b1, cons, hv, ex);
      if (cons && hv) begin
        ok = 1'b1;
        y = out_y;
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_op = '0;
    out_ready = 1'b0; clr_count = 1'b0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({out_valid, out_y, out_zero, out_ones, out_par, xfer_count} !== 16'h0)
      $display("FAIL reset_outputs got v=%b y=%h z=%b o=%b p=%b cnt=%0d want all 0",
               out_valid, out_y, out_zero, out_ones, out_par, xfer_count);
    else n_pass++;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL reset_in_ready got %b want 1", in_ready);
    else n_pass++;
    rst_n = 1'b1;
    #1;
    n_checks++;
    if (in_ready !== 1'b1) $display("FAIL post_reset_in_ready got %b want 1", in_ready);
    else n_pass++;
  endtask

  task automatic test_ops();
    logic [7:0] want [0:7];
    bit acc, cons, hv;
    exp_t ex;
    int k;
    want = '{8'h30, 8'hFC, 8'h0F, 8'hC3, 8'hCF, 8'h03, 8'hCC, 8'h33};
    k = 0;
    for (int j = 0; j < 12; j++) begin
      drive_cycle(j < 8, 8'hF0, 8'h3C, 3'(j), 1'b1, 1'b0, acc, cons, hv, ex);
      n_checks++;
      if (out_valid !== (j >= 2 && j <= 9))
        $display("FAIL ops_latency cycle %0d got out_valid=%b want %b", j, out_valid, (j >= 2 && j <= 9));
      else n_pass++;
      if (cons && k < 8) begin
        n_checks++;
        if (out_y !== want[k]) $display("FAIL ops_result op %0d got %h want %h", k, out_y, want[k]);
        else n_pass++;
        k++;
      end
    end
  endtask

  task automatic test_flags();
    logic [7:0] a [0:2];
    logic [7:0] b [0:2];
    logic [2:0] op [0:2];
    logic [10:0] want [0:2];
    bit ok;
    logic [7:0] y;
    exp_t ex;
    a = '{8'h0F, 8'hFF, 8'h01};
    b = '{8'hF0, 8'h00, 8'h00};
    op = '{3'd0, 3'd1, 3'd6};
    want = '{{8'h00, 3'b100}, {8'hFF, 3'b010}, {8'h01, 3'b001}};
    for (int i = 0; i < 3; i++) begin
      send_one(a[i], b[i], op[i], ok, y, ex);
      n_checks++;
      if (!ok || {out_y, out_zero, out_ones, out_par} !== want[i])
        $display("FAIL flags case %0d got y=%h z=%b o=%b p=%b want %h", i, out_y, out_zero, out_ones, out_par, want[i]);
      else n_pass++;
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] ba [0:3];
    logic [7:0] bb [0:3];
    logic [2:0] bo [0:3];
    logic [7:0] held;
    bit acc, cons, hv;
    exp_t ex;
    int idx, got;
    for (int i = 0; i < 4; i++) begin
      ba[i] = 8'($urandom); bb[i] = 8'($urandom); bo[i] = 3'($urandom);
    end
    idx = 0;
    held = '0;
    for (int c = 0; c < 6; c++) begin
      drive_cycle(idx < 4, ba[idx % 4], bb[idx % 4], bo[idx % 4], 1'b0, 1'b0, acc, cons, hv, ex);
      if (acc) idx++;
      if (c == 2) begin
        held = out_y;
        n_checks++;
        if (!out_valid || exp_q.size() == 0 || out_y !== exp_q[0].y)
          $display("FAIL bp_first got v=%b y=%h want v=1 y=%h", out_valid, out_y, exp_q.size() > 0 ? exp_q[0].y : 8'hxx);
        else n_pass++;
      end else if (c > 2) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_y !== held)
          $display("FAIL bp_hold cycle %0d got v=%b y=%h want v=1 y=%h", c, out_valid, out_y, held);
        else n_pass++;
      end
    end
    n_checks++;
    if (idx != 2 || in_ready !== 1'b0)
      $display("FAIL bp_stall got accepts=%0d in_ready=%b want 2 and 0", idx, in_ready);
    else n_pass++;
    got = 0;
    for (int c = 0; c < 20; c++) begin
      drive_cycle(idx < 4, ba[idx % 4], bb[idx % 4], bo[idx % 4], 1'b1, 1'b0, acc, cons, hv, ex);
      if (acc) idx++;
      if (cons) begin
        n_checks++;
        if (!hv || out_y !== ex.y) $display("FAIL bp_order beat %0d got %h want %h", got, out_y, ex.y);
        else n_pass++;
        got++;
      end
    end
    n_checks++;
    if (got != 4 || out_valid !== 1'b0) $display("FAIL bp_count got %0d results want 4", got);
    else n_pass++;
  endtask

  task automatic test_counter();
    bit acc, cons, hv, ok;
    logic [7:0] y;
    exp_t ex;
    drive_cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1, acc, cons, hv, ex);
    idle(1'b1, cons, hv, ex);
    n_checks++;
    if (xfer_count !== 4'd0) $display("FAIL cnt_clear got %0d want 0", xfer_count);
    else n_pass++;
    for (int k = 1; k <= 16; k++) begin
      send_one(8'($urandom), 8'($urandom), 3'($urandom), ok, y, ex);
      idle(1'b1, cons, hv, ex);
      if (k >= 14) begin
        n_checks++;
        if (!ok || xfer_count !== 4'(k % 16)) $display("FAIL cnt_wrap after %0d got %0d want %0d", k, xfer_count, k % 16);
        else n_pass++;
      end
    end
    send_one(8'h12, 8'h34, 3'd6, ok, y, ex);
    send_one(8'h12, 8'h34, 3'd6, ok, y, ex);
    idle(1'b1, cons, hv, ex);
    n_checks++;
    if (xfer_count !== 4'd2) $display("FAIL cnt_pre_clr got %0d want 2", xfer_count);
    else n_pass++;
    drive_cycle(1'b1, 8'h55, 8'hAA, 3'd1, 1'b1, 1'b0, acc, cons, hv, ex);
    idle(1'b1, cons, hv, ex);
    drive_cycle(1'b0, 8'h00, 8'h00, 3'd0, 1'b1, 1'b1, acc, cons, hv, ex);
    n_checks++;
    if (!cons) $display("FAIL cnt_coincide_xfer got out_valid=%b want 1", out_valid);
    else n_pass++;
    idle(1'b1, cons, hv, ex);
    n_checks++;
    if (xfer_count !== 4'd0) $display("FAIL cnt_clr_priority got %0d want 0", xfer_count);
    else n_pass++;
  endtask

  task automatic test_reset_mid();
    bit acc, cons, hv, ok;
    logic [7:0] y;
    exp_t ex;
    int n;
    send_one(8'h0F, 8'h0F, 3'd0, ok, y, ex);
    n = 0;
    for (int c = 0; c < 2; c++) begin
      drive_cycle(1'b1, 8'($urandom), 8'($urandom), 3'($urandom), 1'b0, 1'b0, acc, cons, hv, ex);
      if (acc) n++;
    end
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    exp_q.delete();
    n_checks++;
    if (n != 2 || out_valid !== 1'b0 || xfer_count !== 4'd0 || in_ready !== 1'b1)
      $display("FAIL rst_mid got acc=%0d v=%b cnt=%0d rdy=%b want 2 0 0 1", n, out_valid, xfer_count, in_ready);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      idle(1'b1, cons, hv, ex);
      n_checks++;
      if (out_valid !== 1'b0) $display("FAIL rst_stale cycle %0d got out_valid=%b want 0", c, out_valid);
      else n_pass++;
    end
  endtask

  task automatic test_random();
    bit acc, cons, hv, prev_hold;
    logic [7:0] prev_y;
    exp_t ex;
    int accepted, cyc;
    accepted = 0;
    cyc = 0;
    prev_hold = 1'b0;
    prev_y = '0;
    while ((accepted < 10000 || exp_q.size() > 0) && cyc < 60000) begin
      drive_cycle(accepted < 10000 && ($urandom_range(0, 9) < 7), 8'($urandom), 8'($urandom),
                  3'($urandom), $urandom_range(0, 9) < 7, 1'b0, acc, cons, hv, ex);
      cyc++;
      if (acc) accepted++;
      if (prev_hold) begin
        n_checks++;
        if (out_valid !== 1'b1 || out_y !== prev_y)
          $display("FAIL rnd_hold cycle %0d got v=%b y=%h want v=1 y=%h", cyc, out_valid, out_y, prev_y);
        else n_pass++;
      end
      if (cons) begin
        n_checks++;
        if (!hv || {out_y, out_zero, out_ones, out_par} !== {ex.y, ex.z, ex.o, ex.p})
          $display("FAIL rnd_result cycle %0d got %h/%b%b%b want %h/%b%b%b", cyc,
                   out_y, out_zero, out_ones, out_par, ex.y, ex.z, ex.o, ex.p);
        else n_pass++;
      end
      prev_hold = out_valid && !out_ready;
      prev_y = out_y;
    end
    n_checks++;
    if (accepted != 10000 || exp_q.size() != 0)
      $display("FAIL rnd_drain got accepted=%0d pending=%0d want 10000 and 0", accepted, exp_q.size());
    else n_pass++;
  endtask

  initial begin
    test_reset();
    test_ops();
    test_flags();
    test_backpressure();
    test_counter();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
